// File: rtl/iterative_multiplier_engine.sv
// Multi-cycle shift-add RV32M multiplier: one partial product per cycle, 32 steps.
// Optional multiplier truncation enabled by defining APX_ACC_CONTROL_EN.
module iterative_multiplier_engine #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [7:0]      accuracy_level,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [1:0]      state_dbg
);

  // Handshake: a request is taken on any rising edge where start=1, funct3[2]=0
  // and the engine is not in CALC; done is a one-cycle pulse with result valid.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [4:0]        count;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_step;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   mcand;
  logic              neg;
  logic              low_half;
  logic              accept;
  logic              last_step;
  logic              signed1, signed2, s1, s2;
  logic [XLEN-1:0]   mag1, mag2, mag2_apx, mask;
  logic [4:0]        k;
  logic [XLEN:0]     sum;
  logic              unused_bits;

`ifdef APX_ACC_CONTROL_EN
  assign k           = accuracy_level[4:0];
  assign unused_bits = ^accuracy_level[7:5];
`else
  assign k           = 5'd0;
  assign unused_bits = ^accuracy_level;
`endif

  always_comb begin
    accept    = start && !funct3[2] && (state != CALC);
    last_step = (state == CALC) && (count == 5'd31);
    // MUL is treated as unsigned: the low half is the same either way
    signed1   = (funct3 == 3'b001) || (funct3 == 3'b010);
    signed2   = (funct3 == 3'b001);
    s1        = signed1 & rs1[XLEN-1];
    s2        = signed2 & rs2[XLEN-1];
    mag1      = s1 ? -rs1 : rs1;
    mag2      = s2 ? -rs2 : rs2;
    mask      = {XLEN{1'b1}} << k;
    mag2_apx  = mag2 & mask;
    sum       = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mcand};
    acc_step  = acc[0] ? {sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};
    product   = neg ? -acc_step : acc_step;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = CALC;
      CALC:    if (last_step) state_next = DONE;
      DONE:    state_next = accept ? CALC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy      = (state == CALC);
  assign done      = (state == DONE);
  assign state_dbg = state;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      count    <= 5'd0;
      acc      <= '0;
      mcand    <= '0;
      neg      <= 1'b0;
      low_half <= 1'b0;
      result   <= '0;
    end else if (accept) begin
      mcand    <= mag1;
      acc      <= {{XLEN{1'b0}}, mag2_apx};
      count    <= 5'd0;
      neg      <= s1 ^ s2;
      low_half <= (funct3[1:0] == 2'b00);
    end else if (state == CALC) begin
      acc   <= acc_step;
      count <= count + 5'd1;
      if (last_step)
        result <= low_half ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
    end
  end

endmodule

// File: tb/tb_iterative_multiplier_engine.sv
// Directed bench for iterative_multiplier_engine: reset, signed/unsigned halves,
// approximation, ignored requests and back-to-back operation.
module tb_iterative_multiplier_engine;

  logic        CLK = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [7:0]  accuracy_level;
  logic [31:0] rs1, rs2;
  logic        busy, done;
  logic [31:0] result;
  logic [1:0]  state_dbg;

  int tests_run    = 0;
  int tests_failed = 0;

  iterative_multiplier_engine #(.XLEN(32)) dut (
    .CLK(CLK), .reset(reset), .start(start), .funct3(funct3),
    .accuracy_level(accuracy_level), .rs1(rs1), .rs2(rs2),
    .busy(busy), .done(done), .result(result), .state_dbg(state_dbg)
  );

  always #5 CLK = ~CLK;

  // Drive one request so that it is sampled on the next rising edge
  task automatic accept_only(input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] b, input logic [7:0] kl);
    @(negedge CLK);
    start = 1'b1; funct3 = f3; rs1 = a; rs2 = b; accuracy_level = kl;
    @(posedge CLK);
    #1 start = 1'b0;
  endtask

  // lat = edges from accept to done (-1 on timeout); bsy = cycles busy seen
  task automatic wait_done(output logic [31:0] res, output int lat, output int bsy);
    lat = -1; bsy = 0; res = 'x;
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLK);
      if (busy) bsy++;
      if (done) begin
        lat = k - 1; res = result;
        break;
      end
    end
  endtask

  task automatic test_reset();
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", done); end
    tests_run++;
    if (result !== 32'h0) begin tests_failed++; $display("FAIL reset_result: got %h expected 0", result); end
  endtask

  task automatic test_reset_mid_calc();
    logic [31:0] r; int lat, bsy, pulses;
    accept_only(3'b000, 32'd10, 32'd20, 8'd0);
    repeat (10) @(negedge CLK);
    reset = 1'b1;
    #1;
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL abort_busy: got %b expected 0", busy); end
    @(negedge CLK) reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (done) pulses++;
    end
    tests_run++;
    if (pulses !== 0) begin tests_failed++; $display("FAIL abort_no_done: got %0d pulses expected 0", pulses); end
    tests_run++;
    if (result !== 32'h0) begin tests_failed++; $display("FAIL abort_result: got %h expected 0", result); end
    accept_only(3'b000, 32'd10, 32'd20, 8'd0);
    wait_done(r, lat, bsy);
    tests_run++;
    if (r !== 32'd200) begin tests_failed++; $display("FAIL after_abort_mul: got %0d expected 200", r); end
    tests_run++;
    if (lat !== 32) begin tests_failed++; $display("FAIL after_abort_latency: got %0d expected 32", lat); end
  endtask

  task automatic test_signed_mul();
    logic [31:0] r; int lat, bsy;
    accept_only(3'b000, 32'hFFFFFFFD, 32'd7, 8'd0);
    wait_done(r, lat, bsy);
    tests_run++;
    if (r !== 32'hFFFFFFEB) begin tests_failed++; $display("FAIL mul_neg: got %h expected ffffffeb", r); end
    tests_run++;
    if (lat !== 32) begin tests_failed++; $display("FAIL mul_latency: got %0d expected 32", lat); end
    tests_run++;
    if (bsy !== 32) begin tests_failed++; $display("FAIL mul_busy_cycles: got %0d expected 32", bsy); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL mul_busy_at_done: got %b expected 0", busy); end
    @(negedge CLK);
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("FAIL mul_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_high_halves();
    logic [31:0] r; int lat, bsy;
    accept_only(3'b001, 32'h80000000, 32'h80000000, 8'd0);
    wait_done(r, lat, bsy);
    tests_run++;
    if (r !== 32'h40000000) begin tests_failed++; $display("FAIL mulh: got %h expected 40000000", r); end
    accept_only(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'd0);
    wait_done(r, lat, bsy);
    tests_run++;
    if (r !== 32'hFFFFFFFE) begin tests_failed++; $display("FAIL mulhu: got %h expected fffffffe", r); end
    accept_only(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'd0);
    wait_done(r, lat, bsy);
    tests_run++;
    if (r !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL mulhsu: got %h expected ffffffff", r); end
  endtask

  task automatic test_approx();
    logic [31:0] r, exp_k3; int lat, bsy;
`ifdef APX_ACC_CONTROL_EN
    exp_k3 = 32'd160;
`else
    exp_k3 = 32'd200;
`endif
    accept_only(3'b000, 32'd10, 32'd20, 8'd0);
    wait_done(r, lat, bsy);
    tests_run++;
    if (r !== 32'd200) begin tests_failed++; $display("FAIL apx_k0: got %0d expected 200", r); end
    accept_only(3'b000, 32'd10, 32'd20, 8'd2);
    wait_done(r, lat, bsy);
    tests_run++;
    if (r !== 32'd200) begin tests_failed++; $display("FAIL apx_k2: got %0d expected 200", r); end
    accept_only(3'b000, 32'd10, 32'd20, 8'd3);
    wait_done(r, lat, bsy);
    tests_run++;
    if (r !== exp_k3) begin tests_failed++; $display("FAIL apx_k3: got %0d expected %0d", r, exp_k3); end
    tests_run++;
    if (lat !== 32) begin tests_failed++; $display("FAIL apx_latency: got %0d expected 32", lat); end
  endtask

  task automatic test_start_in_calc();
    logic [31:0] r; int lat, bsy;
    accept_only(3'b000, 32'd10, 32'd20, 8'd0);
    repeat (5) @(negedge CLK);
    start = 1'b1; funct3 = 3'b000; rs1 = 32'd3; rs2 = 32'd3;
    @(negedge CLK) start = 1'b0;
    wait_done(r, lat, bsy);
    tests_run++;
    if (r !== 32'd200) begin tests_failed++; $display("FAIL calc_start_ignored: got %0d expected 200", r); end
    tests_run++;
    if (lat !== 26) begin tests_failed++; $display("FAIL calc_start_timing: got %0d expected 26", lat); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; int lat, bsy, gap;
    accept_only(3'b000, 32'd5, 32'd6, 8'd0);
    start = 1'b1; rs1 = 32'd7; rs2 = 32'd8;
    wait_done(r, lat, bsy);
    tests_run++;
    if (r !== 32'd30) begin tests_failed++; $display("FAIL b2b_first: got %0d expected 30", r); end
    @(posedge CLK);
    #1 start = 1'b0;
    gap = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLK);
      if (done) begin gap = k; r = result; break; end
    end
    tests_run++;
    if (gap !== 33) begin tests_failed++; $display("FAIL b2b_spacing: got %0d expected 33", gap); end
    tests_run++;
    if (r !== 32'd56) begin tests_failed++; $display("FAIL b2b_second: got %0d expected 56", r); end
  endtask

  task automatic test_invalid_funct3();
    accept_only(3'b100, 32'd9, 32'd9, 8'd0);
    tests_run++;
    if (state_dbg !== 2'd0) begin tests_failed++; $display("FAIL invalid_state: got %0d expected 0", state_dbg); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL invalid_busy: got %b expected 0", busy); end
    repeat (35) @(negedge CLK);
    tests_run++;
    if (result !== 32'd56) begin tests_failed++; $display("FAIL invalid_result: got %0d expected 56", result); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; funct3 = 3'b000; accuracy_level = 8'd0;
    rs1 = '0; rs2 = '0;
    repeat (2) @(negedge CLK);
    test_reset();
    reset = 1'b0;
    test_reset_mid_calc();
    test_signed_mul();
    test_high_halves();
    test_approx();
    test_start_in_calc();
    test_back_to_back();
    test_invalid_funct3();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
